// File: rtl/posit_raw_encode_es2.sv
// posit_raw_encode_es2: 3-stage raw {sgn,scale,frac,inf,zero} to ES=2 posit encoder with RNE.
module posit_raw_encode_es2 #(
  parameter int NBITS = 32,
  parameter int FRAC_W = 30,
  parameter int SCALE_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SCALE_W+FRAC_W+2:0]   in_i,
  input  logic                        truncated_i,
  input  logic                        start_i,
  output logic [NBITS-1:0]            result_o,
  output logic                        done_o
);
  localparam int W = 2*NBITS;
  localparam int SW = $clog2(W);
  localparam logic signed [SCALE_W-1:0] SMAX = SCALE_W'(4*(NBITS-2));
  logic                      v0_q, tr0_q;
  logic [SCALE_W+FRAC_W+2:0] in_q;
  logic                      sg0, inf0, zr0;
  logic signed [SCALE_W-1:0] sc0, k0;
  logic [FRAC_W-1:0]         fr0;
  logic [SW-1:0]             sh0;
  logic                      v1_q, sg1_q, nar1_q, zr1_q, sp1_q, sn1_q, kn1_q, tr1_q;
  logic [SW-1:0]             sh1_q;
  logic [1:0]                e1_q;
  logic [FRAC_W-1:0]         fr1_q;
  logic [W-1:0]              rg2, m2;
  logic                      v2_q, sg2_q, nar2_q, zr2_q, g2_q, st2_q;
  logic [NBITS-2:0]          mg2_q;
  logic [NBITS-1:0]          rnd3, mag3, res_d, result_q;
  logic                      done_q;
  always_ff @(posedge clk) begin
    if (!rst_n) v0_q <= 1'b0;
    else v0_q <= start_i === 1'b1;
    in_q <= in_i;
    tr0_q <= truncated_i;
  end
  assign {sg0, sc0, fr0, inf0, zr0} = in_q;
  assign k0 = sc0 >>> 2;
  // shift amount is the regime run length: k+1 ones, or -k zeros
  assign sh0 = SW'(k0[SCALE_W-1] ? -k0 : k0 + 1'b1);
  always_ff @(posedge clk) begin
    if (!rst_n) v1_q <= 1'b0;
    else v1_q <= v0_q;
    sg1_q <= sg0;
    nar1_q <= inf0;
    zr1_q <= zr0;
    sp1_q <= sc0 >= SMAX;
    sn1_q <= sc0 <= -SMAX;
    kn1_q <= k0[SCALE_W-1];
    sh1_q <= sh0;
    e1_q <= sc0[1:0];
    fr1_q <= fr0;
    tr1_q <= tr0_q;
  end
  assign rg2 = kn1_q ? {1'b1, {W-1{1'b0}}} >> sh1_q : ~({W{1'b1}} >> sh1_q);
  assign m2 = rg2 | ({1'b0, e1_q, fr1_q, {W-3-FRAC_W{1'b0}}} >> sh1_q);
  always_ff @(posedge clk) begin
    if (!rst_n) v2_q <= 1'b0;
    else v2_q <= v1_q;
    sg2_q <= sg1_q;
    nar2_q <= nar1_q;
    zr2_q <= zr1_q;
    mg2_q <= sp1_q ? '1 : sn1_q ? (NBITS-1)'(1) : m2[W-1 -: NBITS-1];
    g2_q <= !(sp1_q || sn1_q) && m2[W-NBITS];
    st2_q <= tr1_q || |m2[W-NBITS-1:0];
  end
  assign rnd3 = {1'b0, mg2_q} + NBITS'(g2_q & (st2_q | mg2_q[0]));
  assign mag3 = rnd3[NBITS-1] ? {1'b0, {NBITS-1{1'b1}}} : rnd3 == '0 ? NBITS'(1) : rnd3;
  assign res_d = nar2_q ? {1'b1, {NBITS-1{1'b0}}} : zr2_q ? '0 : sg2_q ? -mag3 : mag3;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= v2_q;
      if (v2_q) result_q <= res_d;
    end
  end
  assign result_o = result_q;
  assign done_o = done_q;
endmodule
